insn_prefetch: RTL

INSN_PREFETCH -- requirements
Module: insn_prefetch

---
 rtl/insn_prefetch.sv | 120 ++++++++++++
 1 files changed

// File: rtl/insn_prefetch.sv
// Instruction prefetch buffer: issues credit-gated fetches to a one-cycle-latency
// instruction memory and queues {insn, pc} pairs for decode, flushing on redirect.
module insn_prefetch #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_insn,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        insn_valid,
    output logic [31:0] insn_data,
    output logic [31:0] insn_pc,
    input  logic        insn_ready,
    output logic [15:0] fetch_count
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW:0] DepthC = DEPTH[CntW:0];

    logic [31:0]     pc_q, pc_d;
    logic [CntW-1:0] count_q, count_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic            inflight_q, inflight_d;
    logic [31:0]     inflight_pc_q, inflight_pc_d;
    logic [15:0]     fetch_count_q, fetch_count_d;

    logic [31:0]     insn_mem [DEPTH];
    logic [31:0]     pc_mem   [DEPTH];

    logic            push;
    logic            pop;
    logic [CntW:0]   credit_used;
    logic            unused_redirect_lsb;

    assign unused_redirect_lsb = ^redirect_pc[1:0];

    // Buffered entries plus the outstanding response must leave a free slot,
    // so a response always has somewhere to land.
    assign credit_used = {1'b0, count_q} + {{CntW{1'b0}}, inflight_q};
    assign imem_req    = !rst && !redirect_valid && (credit_used < DepthC);
    assign imem_addr   = pc_q;

    assign push = inflight_q && !redirect_valid;
    assign pop  = insn_valid && insn_ready && !redirect_valid;

    assign insn_valid  = (count_q != '0);
    assign insn_data   = insn_mem[rd_ptr_q];
    assign insn_pc     = pc_mem[rd_ptr_q];
    assign fetch_count = fetch_count_q;

    always_comb begin
        pc_d          = pc_q;
        count_d       = count_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        fetch_count_d = fetch_count_q;

        if (redirect_valid) begin
            pc_d     = {redirect_pc[31:2], 2'b00};
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (imem_req) begin
                pc_d          = pc_q + 32'd4;
                inflight_d    = 1'b1;
                inflight_pc_d = pc_q;
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_d      = rd_ptr_q + PtrW'(1);
                fetch_count_d = fetch_count_q + 16'd1;
            end
            if (push && !pop) begin
                count_d = count_q + CntW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CntW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            count_q       <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            fetch_count_q <= '0;
        end else begin
            pc_q          <= pc_d;
            count_q       <= count_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    // Storage needs no reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            insn_mem[wr_ptr_q] <= imem_insn;
            pc_mem[wr_ptr_q]   <= inflight_pc_q;
        end
    end

endmodule
